// File: rtl/axis_pkt_pad_keep.sv
// AXI-Stream transmit padder: packets shorter than MIN_BEATS are extended with filler beats (tdata=0, tkeep=0).
// Optional padding statistics are built only when AXIS_PAD_STATS_EN is defined.
//   state | meaning
//   PASS  | upstream beats are forwarded, beat_cnt tracks packet length
//   PAD   | upstream stalled, filler beats emitted until MIN_BEATS reached
module axis_pkt_pad_keep #(
  parameter int DSIZE     = 8,
  parameter int KSIZE     = 1,
  parameter int USIZE     = 1,
  parameter int MIN_BEATS = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic [KSIZE-1:0] s_axis_tkeep,
  input  logic [USIZE-1:0] s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic [KSIZE-1:0] m_axis_tkeep,
  output logic [USIZE-1:0] m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [15:0]      pad_pkt_cnt,
  output logic [31:0]      pad_beat_cnt
);

  typedef enum logic {PASS, PAD} state_t;

  localparam logic [16:0] MIN_W = 17'(MIN_BEATS);

  state_t           state_q;
  logic [15:0]      beat_cnt_q;
  logic [USIZE-1:0] user_q;
  logic [DSIZE-1:0] tdata_q;
  logic [KSIZE-1:0] tkeep_q;
  logic [USIZE-1:0] tuser_q;
  logic             tlast_q;
  logic             tvalid_q;
  logic             load;
  logic [16:0]      beat_inc;

  assign load          = !tvalid_q || m_axis_tready;
  assign beat_inc      = {1'b0, beat_cnt_q} + 17'd1;
  // Gated by rst so upstream never sees ready while reset is still asserted.
  assign s_axis_tready = !rst && (state_q == PASS) && load;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= PASS;
      beat_cnt_q <= '0;
      user_q     <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else if (load) begin
      case (state_q)
        PASS: begin
          if (s_axis_tvalid) begin
            tvalid_q <= 1'b1;
            tdata_q  <= s_axis_tdata;
            tkeep_q  <= s_axis_tkeep;
            tuser_q  <= s_axis_tuser;
            if (s_axis_tlast && (beat_inc >= MIN_W)) begin
              tlast_q    <= 1'b1;
              beat_cnt_q <= '0;
            end else if (s_axis_tlast) begin
              tlast_q    <= 1'b0;
              user_q     <= s_axis_tuser;
              beat_cnt_q <= beat_inc[15:0];
              state_q    <= PAD;
            end else begin
              tlast_q <= 1'b0;
              if (beat_inc <= MIN_W) beat_cnt_q <= beat_inc[15:0];
            end
          end else begin
            tvalid_q <= 1'b0;
          end
        end
        PAD: begin
          tvalid_q <= 1'b1;
          tdata_q  <= '0;
          tkeep_q  <= '0;
          tuser_q  <= user_q;
          if (beat_inc >= MIN_W) begin
            tlast_q    <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= PASS;
          end else begin
            tlast_q    <= 1'b0;
            beat_cnt_q <= beat_inc[15:0];
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

`ifdef AXIS_PAD_STATS_EN
  logic [15:0] pad_pkt_q;
  logic [31:0] pad_beat_q;
  logic        filler_q;

  // filler_q marks that the beat currently held in the output register is a filler beat.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pad_pkt_q  <= '0;
      pad_beat_q <= '0;
      filler_q   <= 1'b0;
    end else begin
      if (load) filler_q <= (state_q == PAD);
      if (load && (state_q == PASS) && s_axis_tvalid && s_axis_tlast && (beat_inc < MIN_W))
        pad_pkt_q <= pad_pkt_q + 16'd1;
      if (tvalid_q && m_axis_tready && filler_q)
        pad_beat_q <= pad_beat_q + 32'd1;
    end
  end

  assign pad_pkt_cnt  = pad_pkt_q;
  assign pad_beat_cnt = pad_beat_q;
`else
  assign pad_pkt_cnt  = '0;
  assign pad_beat_cnt = '0;
`endif

endmodule
